// File: rtl/fetch_queue_pkg.sv
// rtl/fetch_queue_pkg.sv - shared types and constants for the fetch queue
package fetch_queue_pkg;

    localparam int FQ_DEPTH_DEFAULT = 4;
    localparam int FQ_XLEN_DEFAULT  = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [FQ_XLEN_DEFAULT-1:0] pc;
        logic [FQ_XLEN_DEFAULT-1:0] pc_plus_4;
        logic [FQ_XLEN_DEFAULT-1:0] instr;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue_fq_ptr.sv
// rtl/fetch_queue_fq_ptr.sv - wrapping pointer register with increment and clear
module fq_ptr #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] ptr
);

    // Wraps from 2**W-1 to 0 by natural overflow.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + W'(1);
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - fetch-to-decode instruction buffer; optional FETCH_QUEUE_ALIGN_CHECK_EN
import fetch_queue_pkg::*;

module fetch_queue #(
    parameter int DEPTH = FQ_DEPTH_DEFAULT,
    parameter int XLEN  = FQ_XLEN_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [XLEN-1:0]            in_pc,
    input  logic [XLEN-1:0]            in_pc_plus_4,
    input  logic [XLEN-1:0]            in_instr,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_pc,
    output logic [XLEN-1:0]            out_pc_plus_4,
    output logic [XLEN-1:0]            out_instr,
`ifdef FETCH_QUEUE_ALIGN_CHECK_EN
    output logic                       out_misaligned,
`endif
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus_4;
        logic [XLEN-1:0] instr;
    } entry_t;

    entry_t        mem [DEPTH];
    entry_t        head;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    assign in_ready  = (count != CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Flush clears the pointers, so a push or pop in the same cycle is dropped.
    fq_ptr #(.W(PW)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .inc (push),
        .clr (flush),
        .ptr (wr_ptr)
    );

    fq_ptr #(.W(PW)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .inc (pop),
        .clr (flush),
        .ptr (rd_ptr)
    );

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= '{pc: in_pc, pc_plus_4: in_pc_plus_4, instr: in_instr};
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            count <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        head          = mem[rd_ptr];
        out_pc        = '0;
        out_pc_plus_4 = '0;
        out_instr     = XLEN'(NOP_INSTR);
        if (out_valid) begin
            out_pc        = head.pc;
            out_pc_plus_4 = head.pc_plus_4;
            out_instr     = head.instr;
        end
    end

`ifdef FETCH_QUEUE_ALIGN_CHECK_EN
    assign out_misaligned = out_valid && (out_pc[1:0] != 2'b00);
`endif

endmodule
